adc_spi_capture: RTL and testbench
==================================

// Module: adc_spi_capture
// PURPOSE
//  Drives the dual-channel 14-bit serial ADC (AD_CONV / SPI_SCK / AD_DOUT).
//  Each frame yields one sample per channel, packed into a 32-bit word and
//  written into the sample FIFO. The byte splitter / UART path drains that FIFO.
//  Sits between the ADC pins and the FIFO write port; free-runs at a fixed
//  sample rate while en=1.
// PARAMETERS
//  SCK_HALF       2     clk cycles per SCK half-period (>=1); SCK = clk/(2*SCK_HALF)
//  SAMPLE_PERIOD  1000  clk cycles between consecutive conversion starts
// PORTS
//  clk         in   1   system clock
//  rst         in   1   reset, asynchronous, active-high
//  en          in   1   1 = run periodic conversions; 0 = stop after current frame
//  ad_dout     in   1   ADC serial data; ADC updates it on SCK falling edge
//  ad_conv     out  1   conversion start pulse to ADC
//  spi_sck     out  1   serial clock to ADC, idles low
//  fifo_full   in   1   sample FIFO full flag
//  fifo_din    out  32  {2'b00, chB[13:0], 2'b00, chA[13:0]}
//  fifo_wr_en  out  1   one-clk write strobe
//  overflow    out  1   sticky: a frame was dropped because fifo_full=1
//  busy        out  1   1 while not in IDLE
// BEHAVIOUR
//  Reset values:
//   - ad_conv=0, spi_sck=0, fifo_wr_en=0, fifo_din=0, overflow=0, busy=0.
//   - Internal state: FSM=IDLE, all counters 0.
//  FSM:
//   - IDLE: if en, go to CONV; the period counter restarts at 0.
//   - CONV: ad_conv=1, spi_sck=0 for exactly 2*SCK_HALF clk; then go to SHIFT.
//   - SHIFT: 34 SCK periods. Each period is spi_sck=0 for SCK_HALF clk, then
//     spi_sck=1 for SCK_HALF clk.
//     - ad_dout is sampled on the clk edge that drives spi_sck 0->1.
//     - Bit index n=0..33, MSB first:
//       - n=0,1 / 16,17 / 32,33: discarded (ADC tristate).
//       - n=2..15: chA[13:0].
//       - n=18..31: chB[13:0].
//     - After the 34th high half, spi_sck returns to 0 and the FSM goes to WRITE.
//   - WRITE (1 clk):
//     - If !fifo_full: fifo_din is loaded and fifo_wr_en=1 for exactly this clk.
//     - If fifo_full: no write, fifo_din unchanged, overflow set to 1.
//     - Then go to WAIT.
//   - WAIT: when the period counter reaches SAMPLE_PERIOD-1, go to CONV if en,
//     else IDLE. The counter restarts on entry to CONV.
//  Frame timing:
//   - Frame length = 2*SCK_HALF*35 clk (CONV+SHIFT) + 1 clk (WRITE).
//   - If SAMPLE_PERIOD <= frame length, WAIT lasts 1 clk (back-to-back frames).
//  Output and flag rules:
//   - fifo_din bits 31:30 and 15:14 are always 0.
//   - fifo_din holds its value between writes.
//   - fifo_full is only sampled in WRITE; it is ignored elsewhere.
//   - overflow is cleared only by rst.
//   - en deasserted mid-frame: the frame completes, including WRITE; then IDLE.
//   - en re-asserted during WAIT: has no effect on timing.
//   - rst mid-frame: immediate return to reset values, with no partial write.
//     ad_conv and spi_sck go low asynchronously.
// TESTING (SCK_HALF=2, SAMPLE_PERIOD=200 unless noted)
//  1 Set en=1. The ADC model drives chA=0x2ABC, chB=0x1234 with tristate bits
//    driven to 1 -> exactly one fifo_wr_en pulse with fifo_din=0x12342ABC,
//    140 clk after ad_conv rises. ad_conv is high for 4 clk; there are 34 SCK
//    rising edges.
//  2 en=1 for 5 frames -> ad_conv rising edges are exactly 200 clk apart.
//    There are 5 writes; busy=1 throughout.
//  3 Hold fifo_full=1 during the 2nd WRITE -> no 2nd write and overflow=1.
//    Frames 3+ are written normally and overflow stays 1.
//  4 Deassert en at the 50th SHIFT clk -> that frame is written, then IDLE.
//    busy=0, there is no further ad_conv, and spi_sck stays 0.
//  5 Assert rst at the 80th SHIFT clk -> all outputs read 0 in the same cycle.
//    With en=1 after release, a clean new frame gives the correct word.
//  6 SAMPLE_PERIOD=100 (< frame length) -> WAIT lasts 1 clk and frames run
//    back-to-back. Each frame writes the correct word (chA=0x3FFF, chB=0x0000
//    -> 0x00003FFF).

Source files
------------

// File: rtl/adc_spi_capture_if.sv
// ADC pin and sample-FIFO write-port bundle for adc_spi_capture.
// The master side is the capture engine; the slave side is the ADC/FIFO.
interface adc_spi_capture_if;
    logic        ad_conv;
    logic        spi_sck;
    logic        ad_dout;
    logic        fifo_full;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;

    modport master (
        output ad_conv,
        output spi_sck,
        output fifo_din,
        output fifo_wr_en,
        input  ad_dout,
        input  fifo_full
    );

    modport slave (
        input  ad_conv,
        input  spi_sck,
        input  fifo_din,
        input  fifo_wr_en,
        output ad_dout,
        output fifo_full
    );
endinterface

// File: rtl/adc_spi_capture.sv
// Periodic dual-channel 14-bit serial ADC capture; packs {chB, chA} into one 32-bit
// FIFO word per frame and flags frames dropped on a full FIFO.
module adc_spi_capture #(
    parameter int unsigned SCK_HALF      = 2,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    output logic              o_overflow,
    output logic              o_busy,
    adc_spi_capture_if.master bus
);

    localparam int unsigned ConvLen = 2 * SCK_HALF;
    localparam logic [5:0]  LastBit = 6'd33;

    typedef enum logic [2:0] {StIdle, StConv, StShift, StWrite, StWait} state_e;

    state_e      r_state, w_state;
    logic [31:0] r_cnt, w_cnt;
    logic [31:0] r_per, w_per;
    logic [5:0]  r_bit, w_bit;
    logic        r_sck, w_sck;
    logic        r_ovf, w_ovf;
    logic [27:0] r_sh, w_sh;
    logic [31:0] r_din, w_din;
    logic        w_wr;
    logic        w_keep;
    logic [31:0] w_frame;

    // Only data bits enter the shifter; tristate slots 0,1 / 16,17 / 32,33 are skipped.
    assign w_keep  = ((r_bit >= 6'd2) && (r_bit <= 6'd15)) ||
                     ((r_bit >= 6'd18) && (r_bit <= 6'd31));
    assign w_frame = {2'b00, r_sh[13:0], 2'b00, r_sh[27:14]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_per   <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
            r_ovf   <= 1'b0;
            r_sh    <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_per   <= w_per;
            r_bit   <= w_bit;
            r_sck   <= w_sck;
            r_ovf   <= w_ovf;
            r_sh    <= w_sh;
            r_din   <= w_din;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_per   = r_per + 32'd1;
        w_bit   = r_bit;
        w_sck   = r_sck;
        w_ovf   = r_ovf;
        w_sh    = r_sh;
        w_din   = r_din;
        w_wr    = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_per = '0;
                w_cnt = '0;
                if (i_en) begin
                    w_state = StConv;
                end
            end
            StConv: begin
                if (r_cnt == ConvLen - 1) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_sck   = 1'b0;
                    w_state = StShift;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end
            StShift: begin
                if (r_cnt == SCK_HALF - 1) begin
                    w_cnt = '0;
                    if (!r_sck) begin
                        // ad_dout is taken on the edge that raises SCK.
                        w_sck = 1'b1;
                        if (w_keep) begin
                            w_sh = {r_sh[26:0], bus.ad_dout};
                        end
                    end else begin
                        w_sck = 1'b0;
                        if (r_bit == LastBit) begin
                            w_state = StWrite;
                        end else begin
                            w_bit = r_bit + 6'd1;
                        end
                    end
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end
            StWrite: begin
                if (bus.fifo_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_wr  = 1'b1;
                    w_din = w_frame;
                end
                w_state = StWait;
            end
            StWait: begin
                if (r_per >= SAMPLE_PERIOD - 1) begin
                    w_per   = '0;
                    w_cnt   = '0;
                    w_state = i_en ? StConv : StIdle;
                end
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    // The word is presented during WRITE itself so the FIFO latches it with the strobe.
    assign bus.ad_conv    = (r_state == StConv);
    assign bus.spi_sck    = r_sck;
    assign bus.fifo_wr_en = w_wr;
    assign bus.fifo_din   = w_wr ? w_frame : r_din;
    assign o_overflow     = r_ovf;
    assign o_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: one instance at SAMPLE_PERIOD=200, one at 100.
module tb_adc_spi_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en1 = 1'b0;
    logic en2 = 1'b0;
    logic full1 = 1'b0;
    logic full2 = 1'b0;
    logic ovf1, ovf2, busy1, busy2;
    logic [13:0] a1 = 14'h2ABC, b1 = 14'h1234;
    logic [13:0] a2 = 14'h3FFF, b2 = 14'h0000;
    logic [33:0] fr1, fr2;
    logic dout1 = 1'b1, dout2 = 1'b1;
    int idx1 = 34, idx2 = 34;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    adc_spi_capture_if u_if1 ();
    adc_spi_capture_if u_if2 ();

    adc_spi_capture #(.SCK_HALF(2), .SAMPLE_PERIOD(200)) u_dut1 (
        .clk(clk), .rst(rst), .i_en(en1), .o_overflow(ovf1), .o_busy(busy1), .bus(u_if1.master)
    );
    adc_spi_capture #(.SCK_HALF(2), .SAMPLE_PERIOD(100)) u_dut2 (
        .clk(clk), .rst(rst), .i_en(en2), .o_overflow(ovf2), .o_busy(busy2), .bus(u_if2.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: tristate slots read as 1, new bit after each SCK falling edge.
    assign fr1 = {2'b11, a1, 2'b11, b1, 2'b11};
    assign fr2 = {2'b11, a2, 2'b11, b2, 2'b11};
    assign u_if1.ad_dout   = dout1;
    assign u_if2.ad_dout   = dout2;
    assign u_if1.fifo_full = full1;
    assign u_if2.fifo_full = full2;

    always @(posedge u_if1.ad_conv or negedge u_if1.spi_sck) begin
        if (u_if1.ad_conv) idx1 = 0;
        else idx1 = idx1 + 1;
        dout1 = (idx1 < 34) ? fr1[33 - idx1] : 1'b1;
    end
    always @(posedge u_if2.ad_conv or negedge u_if2.spi_sck) begin
        if (u_if2.ad_conv) idx2 = 0;
        else idx2 = idx2 + 1;
        dout2 = (idx2 < 34) ? fr2[33 - idx2] : 1'b1;
    end

    // Event recorders, sampled on the falling clock edge.
    int conv_n = 0, conv_hi = 0, sck_n = 0, wr_n = 0, busy_lo = 0;
    int conv_t [32];
    int wr_t [32];
    logic [31:0] wr_d [32];
    logic conv_p = 1'b0, sck_p = 1'b0;
    int conv2_n = 0, wr2_n = 0;
    int conv2_t [32];
    logic [31:0] wr2_d [32];
    logic conv2_p = 1'b0;

    always @(negedge clk) begin
        if (u_if1.ad_conv && !conv_p) begin
            if (conv_n < 32) conv_t[conv_n] = cyc;
            conv_n = conv_n + 1;
        end
        if (u_if1.ad_conv) conv_hi = conv_hi + 1;
        if (u_if1.spi_sck && !sck_p) sck_n = sck_n + 1;
        if (u_if1.fifo_wr_en) begin
            if (wr_n < 32) begin
                wr_t[wr_n] = cyc;
                wr_d[wr_n] = u_if1.fifo_din;
            end
            wr_n = wr_n + 1;
        end
        if (!busy1) busy_lo = busy_lo + 1;
        conv_p = u_if1.ad_conv;
        sck_p  = u_if1.spi_sck;
    end

    always @(negedge clk) begin
        if (u_if2.ad_conv && !conv2_p) begin
            if (conv2_n < 32) conv2_t[conv2_n] = cyc;
            conv2_n = conv2_n + 1;
        end
        if (u_if2.fifo_wr_en) begin
            if (wr2_n < 32) wr2_d[wr2_n] = u_if2.fifo_din;
            wr2_n = wr2_n + 1;
        end
        conv2_p = u_if2.ad_conv;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wr(input int n, input int bound, input string tag);
        int k = 0;
        while (wr_n < n && k < bound) begin
            step();
            k++;
        end
        chk(tag, 32'(wr_n >= n), 32'd1);
    endtask

    task automatic wait_conv(input int n, input int bound, input string tag);
        int k = 0;
        while (conv_n < n && k < bound) begin
            step();
            k++;
        end
        chk(tag, 32'(conv_n >= n), 32'd1);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        en1 = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int c0, w0, s0, b0;
        logic [31:0] exp1;

        // Reset values
        repeat (3) step();
        chk("rst_conv", 32'(u_if1.ad_conv), 32'd0);
        chk("rst_sck", 32'(u_if1.spi_sck), 32'd0);
        chk("rst_wr", 32'(u_if1.fifo_wr_en), 32'd0);
        chk("rst_din", u_if1.fifo_din, 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        step();

        // Test 1: single frame word, latency, conv width, SCK count
        en1 = 1'b1;
        wait_conv(1, 20, "t1_conv_seen");
        b0 = busy_lo;
        wait_wr(1, 400, "t1_wr_seen");
        chk("t1_din", wr_d[0], 32'h12342ABC);
        chk("t1_latency", 32'(wr_t[0] - conv_t[0]), 32'd140);
        chk("t1_conv_width", 32'(conv_hi), 32'd4);
        chk("t1_sck_rises", 32'(sck_n), 32'd34);

        // Test 2: five frames at a 200-clk period
        wait_wr(5, 1200, "t2_wr_seen");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_period%0d", i), 32'(conv_t[i + 1] - conv_t[i]), 32'd200);
        end
        chk("t2_writes", 32'(wr_n), 32'd5);
        chk("t2_convs", 32'(conv_n), 32'd5);
        chk("t2_busy", 32'(busy_lo - b0), 32'd0);
        chk("t2_din_last", wr_d[4], 32'h12342ABC);

        // Test 3: FIFO full during the 2nd WRITE
        do_reset();
        c0 = conv_n;
        w0 = wr_n;
        en1 = 1'b1;
        wait_wr(w0 + 1, 400, "t3_wr1_seen");
        chk("t3_ovf_before", 32'(ovf1), 32'd0);
        wait_conv(c0 + 2, 400, "t3_conv2_seen");
        full1 = 1'b1;
        repeat (150) step();
        full1 = 1'b0;
        chk("t3_dropped", 32'(wr_n - w0), 32'd1);
        chk("t3_ovf_set", 32'(ovf1), 32'd1);
        wait_wr(w0 + 3, 600, "t3_wr3_seen");
        chk("t3_din_after", wr_d[w0 + 2], 32'h12342ABC);
        chk("t3_ovf_sticky", 32'(ovf1), 32'd1);

        // Test 4: en dropped at the 50th SHIFT clk
        do_reset();
        c0 = conv_n;
        w0 = wr_n;
        s0 = sck_n;
        en1 = 1'b1;
        wait_conv(c0 + 1, 20, "t4_conv_seen");
        repeat (53) step();
        en1 = 1'b0;
        repeat (400) step();
        chk("t4_written", 32'(wr_n - w0), 32'd1);
        chk("t4_no_conv", 32'(conv_n - c0), 32'd1);
        chk("t4_busy", 32'(busy1), 32'd0);
        chk("t4_sck_rises", 32'(sck_n - s0), 32'd34);
        chk("t4_sck_low", 32'(u_if1.spi_sck), 32'd0);
        chk("t4_din_hold", u_if1.fifo_din, 32'h12342ABC);

        // Test 5: reset at the 80th SHIFT clk, then a clean frame
        c0 = conv_n;
        en1 = 1'b1;
        wait_conv(c0 + 1, 20, "t5_conv_seen");
        w0 = wr_n;
        repeat (83) step();
        chk("t5_sck_high", 32'(u_if1.spi_sck), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_conv", 32'(u_if1.ad_conv), 32'd0);
        chk("t5_sck", 32'(u_if1.spi_sck), 32'd0);
        chk("t5_wr", 32'(u_if1.fifo_wr_en), 32'd0);
        chk("t5_din", u_if1.fifo_din, 32'd0);
        chk("t5_busy", 32'(busy1), 32'd0);
        a1 = 14'h0155;
        b1 = 14'h3AAA;
        exp1 = 32'h3AAA0155;
        repeat (2) step();
        chk("t5_no_partial", 32'(wr_n - w0), 32'd0);
        rst = 1'b0;
        wait_wr(w0 + 1, 400, "t5_wr_seen");
        chk("t5_new_word", wr_d[w0], exp1);
        en1 = 1'b0;

        // Test 6: SAMPLE_PERIOD=100, back-to-back frames
        en2 = 1'b1;
        begin
            int k = 0;
            while (wr2_n < 3 && k < 1000) begin
                step();
                k++;
            end
        end
        chk("t6_wr_seen", 32'(wr2_n >= 3), 32'd1);
        chk("t6_gap0", 32'(conv2_t[1] - conv2_t[0]), 32'd142);
        chk("t6_gap1", 32'(conv2_t[2] - conv2_t[1]), 32'd142);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_din%0d", i), wr2_d[i], 32'h00003FFF);
        end
        chk("t6_ovf", 32'(ovf2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
